gate_response_checker: RTL and testbench

Self-checking response monitor for 2-input, 1-output combinational gates on the EDU-CIAA FPGA designs. It samples the gate inputs and output on each strobe and compares the output against a parameterised truth table. It tracks which input combinations have been exercised and counts mismatches. Its pass/fail verdict is suitable for driving board LEDs, which lets hardware-in-the-loop checks of gate modules run without a simulator.

---
 rtl/gate_response_checker.sv | 172 +++++++++++++++++
 tb/tb_gate_response_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response monitor for a 2-input/1-output gate: checks s against TRUTH_TABLE[{a,b}],
// tracks input coverage and mismatches. Optional run timeout via macro CHECKER_TIMEOUT_EN.
module gate_response_checker #(
   parameter logic [3:0]  TRUTH_TABLE = 4'b1000,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sample_valid,
   input  logic                 a,
   input  logic                 b,
   input  logic                 s,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [3:0]           coverage,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [2:0]           first_fail_vec,
   output logic                 first_fail_valid,
   output logic [1:0]           dbg_state_o
);

   // Handshake: sample_valid is a one-cycle strobe with no back-pressure; every strobe
   // seen in RUN is consumed, except when start is high in the same cycle (start wins).

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   if (ERR_CNT_W < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("gate_response_checker: ERR_CNT_W and TIMEOUT must be at least 1");
   end

   state_t                 state_q, state_d;
   logic [3:0]             cov_q, cov_d;
   logic [ERR_CNT_W-1:0]   err_q, err_d;
   logic [2:0]             ffv_q, ffv_d;
   logic                   ffvalid_q, ffvalid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   fail_q, fail_d;
   logic [1:0]             idx;

   assign idx = {a, b};

`ifdef CHECKER_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   logic             tout_q, tout_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             expire;

   // tmr_q is 0 in the first RUN cycle, so expiry lands on the TIMEOUT-th RUN cycle.
   assign expire = (tmr_q == TMR_W'(TIMEOUT - 1));
`else
   logic tout_d;
   assign tout_d = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cov_q     <= '0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
`ifdef CHECKER_TIMEOUT_EN
         tout_q    <= 1'b0;
         tmr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cov_q     <= cov_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
`ifdef CHECKER_TIMEOUT_EN
         tout_q    <= tout_d;
         tmr_q     <= tmr_d;
`endif
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cov_d     = cov_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
`ifdef CHECKER_TIMEOUT_EN
      tout_d    = tout_q;
      tmr_d     = tmr_q;
`endif
      if (start) begin
         state_d   = ST_RUN;
         cov_d     = '0;
         err_d     = '0;
         ffv_d     = '0;
         ffvalid_d = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
         tout_d    = 1'b0;
         tmr_d     = '0;
`endif
      end else if (state_q == ST_RUN) begin
`ifdef CHECKER_TIMEOUT_EN
         tmr_d = tmr_q + TMR_W'(1);
`endif
         if (sample_valid) begin
            cov_d = cov_q | (4'b0001 << idx);
            if (s != TRUTH_TABLE[idx]) begin
               if (err_q != {ERR_CNT_W{1'b1}}) begin
                  err_d = err_q + ERR_CNT_W'(1);
               end
               if (!ffvalid_q) begin
                  ffv_d     = {a, b, s};
                  ffvalid_d = 1'b1;
               end
            end
         end
         // Completion by coverage takes priority over a coinciding timeout.
         if (cov_d == 4'b1111) begin
            state_d = ST_DONE;
         end
`ifdef CHECKER_TIMEOUT_EN
         else if (expire) begin
            state_d = ST_DONE;
            tout_d  = 1'b1;
         end
`endif
      end
   end

   // Output decode, registered alongside the state
   always_comb begin
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_d == '0) && !tout_d;
      fail_d = done_d && !pass_d;
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail             = fail_q;
   assign coverage         = cov_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;
   assign dbg_state_o      = state_q;
`ifdef CHECKER_TIMEOUT_EN
   assign timeout          = tout_q;
`else
   assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: default-width instance plus a
// 2-bit error counter instance sharing the same stimulus.
module tb_gate_response_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic sample_valid = 1'b0;
   logic a = 1'b0, b = 1'b0, s = 1'b0;

   logic       busy, done, pass, fail, timeout, first_fail_valid;
   logic [3:0] coverage;
   logic [7:0] err_count;
   logic [2:0] first_fail_vec;
   logic [1:0] dbg_state;

   logic       busy2, done2, pass2, fail2, timeout2, first_fail_valid2;
   logic [3:0] coverage2;
   logic [1:0] err_count2;
   logic [2:0] first_fail_vec2;
   logic [1:0] dbg_state2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   gate_response_checker #(.TRUTH_TABLE(4'b1000), .ERR_CNT_W(8), .TIMEOUT(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .s(s),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .coverage(coverage), .err_count(err_count),
      .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid),
      .dbg_state_o(dbg_state)
   );

   gate_response_checker #(.TRUTH_TABLE(4'b1000), .ERR_CNT_W(2), .TIMEOUT(16)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .s(s),
      .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .timeout(timeout2),
      .coverage(coverage2), .err_count(err_count2),
      .first_fail_vec(first_fail_vec2), .first_fail_valid(first_fail_valid2),
      .dbg_state_o(dbg_state2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [2:0] vec);
      sample_valid = 1'b1;
      {a, b, s} = vec;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if ({busy, done, pass, fail, timeout, coverage, err_count, first_fail_vec, first_fail_valid, dbg_state} !== 23'd0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {busy, done, pass, fail, timeout, coverage, err_count, first_fail_vec, first_fail_valid, dbg_state});
      else n_pass++;
   endtask

   task automatic test_pass_run();
      do_start();
      n_checks++;
      if ({busy, done, coverage} !== 6'b10_0000) $display("FAIL pass_busy: got %b expected 100000", {busy, done, coverage});
      else n_pass++;
      send(3'b000);
      n_checks++;
      if (coverage !== 4'b0001) $display("FAIL pass_cov1: got %b expected 0001", coverage);
      else n_pass++;
      send(3'b010);
      send(3'b100);
      n_checks++;
      if ({done, coverage} !== 5'b0_0111) $display("FAIL pass_cov3: got %b expected 00111", {done, coverage});
      else n_pass++;
      send(3'b111);
      n_checks++;
      if ({busy, done, pass, fail, coverage} !== 8'b0110_1111)
         $display("FAIL pass_verdict: got %b expected 01101111", {busy, done, pass, fail, coverage});
      else n_pass++;
      n_checks++;
      if ({err_count, first_fail_valid, timeout} !== 10'd0)
         $display("FAIL pass_errs: got err=%0d ffv=%b to=%b expected 0 0 0", err_count, first_fail_valid, timeout);
      else n_pass++;
   endtask

   task automatic test_single_error();
      do_start();
      send(3'b000);
      send(3'b010);
      send(3'b100);
      send(3'b110);
      n_checks++;
      if ({err_count, first_fail_vec, first_fail_valid} !== {8'd1, 3'b110, 1'b1})
         $display("FAIL err1_capture: got err=%0d vec=%b v=%b expected 1 110 1", err_count, first_fail_vec, first_fail_valid);
      else n_pass++;
      n_checks++;
      if ({done, pass, fail} !== 3'b101) $display("FAIL err1_verdict: got %b expected 101", {done, pass, fail});
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat;
      do_start();
      for (int i = 0; i < 5; i++) begin
         send(3'b110);
         exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
         n_checks++;
         if ({err_count2, done2} !== {exp_sat, 1'b0})
            $display("FAIL sat_step%0d: got err=%0d done=%b expected %0d 0", i, err_count2, done2, exp_sat);
         else n_pass++;
      end
      send(3'b000);
      send(3'b010);
      n_checks++;
      if (done2 !== 1'b0) $display("FAIL sat_early_done: got %b expected 0", done2);
      else n_pass++;
      send(3'b100);
      n_checks++;
      if ({done2, pass2, fail2, err_count2, first_fail_vec2} !== {3'b101, 2'b11, 3'b110})
         $display("FAIL sat_final: got %b expected 10111110", {done2, pass2, fail2, err_count2, first_fail_vec2});
      else n_pass++;
      n_checks++;
      if (err_count !== 8'd5) $display("FAIL sat_wide_count: got %0d expected 5", err_count);
      else n_pass++;
   endtask

   task automatic test_coverage_progress();
      do_start();
      for (int i = 0; i < 6; i++) send(3'b000);
      n_checks++;
      if ({done, coverage} !== 5'b0_0001) $display("FAIL cov_repeat: got %b expected 00001", {done, coverage});
      else n_pass++;
      send(3'b010);
      n_checks++;
      if (coverage !== 4'b0011) $display("FAIL cov_0011: got %b expected 0011", coverage);
      else n_pass++;
      send(3'b100);
      n_checks++;
      if ({done, coverage} !== 5'b0_0111) $display("FAIL cov_0111: got %b expected 00111", {done, coverage});
      else n_pass++;
      send(3'b111);
      n_checks++;
      if ({done, pass, coverage} !== 6'b11_1111) $display("FAIL cov_done: got %b expected 111111", {done, pass, coverage});
      else n_pass++;
   endtask

   task automatic test_start_in_done();
      start = 1'b1;
      sample_valid = 1'b1;
      {a, b, s} = 3'b110;
      tick();
      start = 1'b0;
      sample_valid = 1'b0;
      n_checks++;
      if ({busy, done, pass, fail, coverage, err_count, first_fail_valid} !== {4'b1000, 4'd0, 8'd0, 1'b0})
         $display("FAIL start_wins: got %b expected 1000_0000_00000000_0",
                  {busy, done, pass, fail, coverage, err_count, first_fail_valid});
      else n_pass++;
   endtask

   task automatic test_restart_in_run();
      send(3'b110);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, err_count, first_fail_valid} !== {1'b1, 8'd0, 1'b0})
         $display("FAIL restart_clear: got busy=%b err=%0d ffv=%b expected 1 0 0", busy, err_count, first_fail_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      do_start();
      send(3'b000);
      send(3'b010);
      rst = 1'b1;
      sample_valid = 1'b1;
      {a, b, s} = 3'b100;
      tick();
      rst = 1'b0;
      sample_valid = 1'b0;
      n_checks++;
      if ({busy, done, pass, fail, timeout, coverage, err_count, first_fail_vec, first_fail_valid} !== 21'd0)
         $display("FAIL midrun_reset: got %h expected 0",
                  {busy, done, pass, fail, timeout, coverage, err_count, first_fail_vec, first_fail_valid});
      else n_pass++;
      do_start();
      send(3'b000);
      send(3'b010);
      send(3'b100);
      send(3'b111);
      n_checks++;
      if ({done, pass, fail} !== 3'b110) $display("FAIL post_reset_pass: got %b expected 110", {done, pass, fail});
      else n_pass++;
   endtask

   task automatic test_timeout();
      do_start();
`ifdef CHECKER_TIMEOUT_EN
      for (int i = 0; i < 15; i++) send(3'b000);
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL to_before: got %b expected 10", {busy, done});
      else n_pass++;
      send(3'b000);
      n_checks++;
      if ({busy, done, timeout, pass, fail, coverage} !== 9'b01101_0001)
         $display("FAIL to_expire: got %b expected 011010001", {busy, done, timeout, pass, fail, coverage});
      else n_pass++;
      // Final coverage sample on the expiry cycle: coverage wins.
      do_start();
      for (int i = 0; i < 13; i++) send(3'b000);
      send(3'b010);
      send(3'b100);
      send(3'b111);
      n_checks++;
      if ({done, timeout, pass, fail} !== 4'b1010)
         $display("FAIL to_coincide: got %b expected 1010", {done, timeout, pass, fail});
      else n_pass++;
`else
      for (int i = 0; i < 40; i++) send(3'b000);
      n_checks++;
      if ({busy, done, timeout, coverage} !== 7'b100_0001)
         $display("FAIL no_timeout: got %b expected 1000001", {busy, done, timeout, coverage});
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_pass_run();
      test_single_error();
      test_saturation();
      test_coverage_progress();
      test_start_in_done();
      test_restart_in_run();
      test_reset_mid_run();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
